muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Iterative multiply/divide sequencer for the pipelined MIPS core. It accepts mult/multu/div/divu requests from the EX stage and runs a shift-add multiply or restoring divide over WIDTH cycles. It holds the HI/LO result registers and stalls the pipeline while busy. It sits beside the ALU, driven by the decoded opcode/func of the instruction in EX.

## Interface
- WIDTH, 32, operand width; also the iteration count.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe from EX for one mult/div instruction.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  abort the current operation (branch/jump squash).
- busy  out  1  high in any state except IDLE.
- stall  out  1  start & busy, combinational; freezes IF/ID/EX.
- done  out  1  one-cycle pulse when hi/lo are updated.
- dz  out  1  one-cycle pulse with done for a divide by zero.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

## Operation
- FSM states:
  - IDLE: start & !flush → CALC. Latch operands, op, and sign flags. Load counter = WIDTH.
  - CALC: one iteration per cycle. Decrement counter. At counter 1 → FIX.
  - FIX: apply sign correction; write hi/lo → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Multiply: 2·WIDTH-bit accumulator, shift-add on LSB of multiplier.
- Divide: restoring algorithm. Remainder WIDTH+1 bits; a quotient bit is shifted in each cycle.
- Signed ops (op[0]=0):
  - Operands are converted to magnitude at start.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
- Divide by zero: lo=all ones, hi=a, dz pulses with done. No trap.
- Signed overflow, 0x80000000 / -1: lo=0x80000000, hi=0.
- hi/lo change only in FIX. Between operations they hold their value.
- start while busy is ignored. stall stays asserted until EX re-presents the request after the FSM returns to IDLE.
- flush in any non-IDLE state → IDLE on the next edge. hi/lo are not written and done is not pulsed.
- flush and start together in IDLE: flush wins and the request is dropped.
- rst, asynchronous at any time, including mid-operation:
  - state=IDLE, counter=0, busy=0, done=0, dz=0.
  - hi=0, lo=0, all internal accumulators 0.

## Timing
- start is sampled at edge T0.
- CALC runs during cycles T0+1 … T0+WIDTH, FIX in cycle T0+WIDTH+1, and done is high in cycle T0+WIDTH+2.
- hi/lo are valid from cycle T0+WIDTH+2. For WIDTH=32, done appears 34 cycles after the start edge.
- Latency is fixed and data-independent, with no early termination.
- A back-to-back start is accepted in the IDLE cycle after DONE. Minimum issue interval is WIDTH+3 cycles.
- busy is registered. stall is combinational from start and busy.

## Configuration
- MULDIV_SIGNED_EN defined: signed mult/div are supported as described.
- Undefined:
  - op[0] is ignored and all operations are unsigned.
  - Sign-flag and negation logic is removed.
  - FIX is a pass-through, so latency is unchanged.
  - The 0x80000000 / -1 rule does not apply; that case yields the unsigned result.

## Structure
- Shared package muldiv_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - state typedef (IDLE, CALC, FIX, DONE).
  - default WIDTH constant.
- One sub-module, muldiv_step: combinational single iteration. Inputs are mode, accumulator/remainder, and operand; outputs are the next accumulator and the quotient bit. It is instantiated once and the FSM iterates over it.

## Test plan
- multu a=7, b=6 → done in cycle T0+34; hi=0, lo=42; busy low the following cycle.
- mult a=-3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Without MULDIV_SIGNED_EN → hi=0x00000004, lo=0xFFFFFFF1.
- divu a=100, b=7 → lo=14, hi=2. div a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=55, b=0 → lo=0xFFFFFFFF, hi=55, dz and done pulse together for one cycle.
- Start multu 3×3, then:
  - pulse start while busy → stall=1 that cycle, second request ignored.
  - flush at T0+10 → IDLE at T0+11, no done, hi/lo keep their prior values.
- Assert rst at T0+20 of a divide → busy, done, hi, lo all 0 immediately; a new start after rst release completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
//   - OP_* : encodings of the two-bit op field presented by the EX stage.
//   - state_t : sequencer FSM states.
//   - DEFAULT_WIDTH : operand width, which is also the iteration count.
//   - op_is_div / op_is_signed : decode helpers for the op field.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return !((op == OP_MULT) || (op == OP_MULTU));
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shift-add multiply or restoring divide.
// The accumulator is 2*WIDTH+1 bits wide and is interpreted per mode:
//   multiply: acc[2W:W] = partial product upper part (with carry bit),
//             acc[W-1:0] = remaining multiplier bits (LSB consumed each step).
//   divide:   acc[2W:W] = partial remainder,
//             acc[W-1:0] = dividend bits shifting out at the top while
//                          quotient bits fill in from the bottom.
// Ports:
//   is_div   in   1          selects divide (1) or multiply (0)
//   acc      in   2*WIDTH+1  current accumulator / remainder
//   operand  in   WIDTH      multiplicand (multiply) or divisor (divide)
//   acc_next out  2*WIDTH+1  accumulator after this iteration (LSB slot of a
//                            divide left 0; the caller inserts q_bit)
//   q_bit    out  1          quotient bit produced by a divide iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH:0]   acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else leaves a value unassigned and infers a latch.
  always_comb begin
    acc_next = acc;
    q_bit    = 1'b0;
    sum      = '0;
    shifted  = '0;
    if (is_div) begin
      // Bring the next dividend bit into the remainder, then subtract the
      // divisor only if it fits (restoring step without an explicit restore).
      shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      q_bit    = (shifted >= {1'b0, operand});
      acc_next = {(q_bit ? (shifted - {1'b0, operand}) : shifted),
                  acc[WIDTH-2:0], 1'b0};
    end else begin
      // Add the multiplicand when the current multiplier bit is set, then
      // shift the whole accumulator right by one.
      sum      = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand} : '0);
      acc_next = {1'b0, sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer for the MIPS EX stage. Holds HI/LO and
// stalls the pipeline while an operation is in flight. Latency is fixed:
// WIDTH CALC cycles, one FIX cycle, then a one-cycle DONE pulse.
//
// Build option: define MULDIV_SIGNED_EN to support signed mult/div. Without
// it op[0] is ignored, every operation is unsigned and FIX only transfers the
// raw result (latency unchanged).
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request strobe from EX
//   op     in   2      00 mult, 01 multu, 10 div, 11 divu
//   a      in   WIDTH  rs operand (multiplicand / dividend)
//   b      in   WIDTH  rt operand (multiplier / divisor)
//   flush  in   1      abort the current operation
//   busy   out  1      high in any state other than IDLE (registered)
//   stall  out  1      start & busy (combinational)
//   done   out  1      one-cycle pulse when hi/lo have been updated
//   dz     out  1      divide-by-zero flag, pulses together with done
//   hi     out  WIDTH  product upper half / remainder
//   lo     out  WIDTH  product lower half / quotient
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    count;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] step_acc;
  logic             step_q;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] a_hold;
  logic             is_div;
  logic             b_zero;
  logic             accept;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_nx;
  logic [WIDTH-1:0]   lo_nx;
  logic               dz_nx;

`ifdef MULDIV_SIGNED_EN
  logic sign_a;
  logic sign_b;
  logic start_sign_a;
  logic start_sign_b;
`endif

  assign accept = (state == IDLE) && start && !flush;
  assign stall  = start && busy;

  // Operands enter the datapath as magnitudes; signs are reapplied in FIX.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    start_sign_a = op_is_signed(op) && a[WIDTH-1];
    start_sign_b = op_is_signed(op) && b[WIDTH-1];
    a_mag        = start_sign_a ? (~a + 1'b1) : a;
    b_mag        = start_sign_b ? (~b + 1'b1) : b;
`else
    a_mag = a;
    b_mag = b;
`endif
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC: begin
        if (flush)                  state_nx = IDLE;
        else if (count == CW'(1))   state_nx = FIX;
      end
      FIX:     state_nx = flush ? IDLE : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result correction applied during FIX.
  always_comb begin
    prod  = acc[2*WIDTH-1:0];
    quo   = acc[WIDTH-1:0];
    rem   = acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
    // Negating the magnitude quotient of 0x80000000 / 1 wraps back to
    // 0x80000000, which is exactly the required overflow result.
    if (sign_a ^ sign_b) begin
      prod = ~prod + 1'b1;
      quo  = ~quo + 1'b1;
    end
    if (sign_a) rem = ~rem + 1'b1;
`endif
    hi_nx = prod[2*WIDTH-1:WIDTH];
    lo_nx = prod[WIDTH-1:0];
    dz_nx = 1'b0;
    if (is_div) begin
      if (b_zero) begin
        hi_nx = a_hold;
        lo_nx = '1;
        dz_nx = 1'b1;
      end else begin
        hi_nx = rem;
        lo_nx = quo;
      end
    end
  end

  // NOTE: state elements are written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  // All datapath registers are reset too: hi/lo are architecturally visible
  // and must read zero immediately after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      operand <= '0;
      a_hold  <= '0;
      is_div  <= 1'b0;
      b_zero  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef MULDIV_SIGNED_EN
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      done  <= (state_nx == DONE);
      dz    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_div  <= op_is_div(op);
            a_hold  <= a;
            b_zero  <= (b == '0);
            count   <= CW'(WIDTH);
            // Multiply shifts the multiplier through the low half; divide
            // shifts the dividend through it.
            operand <= op_is_div(op) ? b_mag : a_mag;
            acc     <= {{(WIDTH+1){1'b0}}, (op_is_div(op) ? a_mag : b_mag)};
`ifdef MULDIV_SIGNED_EN
            sign_a  <= start_sign_a;
            sign_b  <= start_sign_b;
`endif
          end
        end
        CALC: begin
          if (!flush) begin
            acc   <= {step_acc[2*WIDTH:1], step_acc[0] | step_q};
            count <= count - 1'b1;
          end
        end
        FIX: begin
          if (!flush) begin
            hi <= hi_nx;
            lo <= lo_nx;
            dz <= dz_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
